// File: rtl/nubus_arb_pkg.sv
// Shared types and constants for the NuBus card-master arbiter.
package nubus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic [3:0] WSTRB_READ = 4'b0000;

  // Requester index reached by stepping 'off' places from 'base', wrapping at n.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/nubus_rr_pick.sv
// Rotate-priority picker: first asserted request at or after ptr, wrapping.
module nubus_rr_pick
  import nubus_arb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [PTR_W-1:0] index,
  output logic             hit
);

  always_comb begin
    onehot = '0;
    index  = '0;
    hit    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hit && req[wrap_idx(int'(ptr), i, NREQ)]) begin
        hit = 1'b1;
        onehot[wrap_idx(int'(ptr), i, NREQ)] = 1'b1;
        index = PTR_W'(wrap_idx(int'(ptr), i, NREQ));
      end
    end
  end

endmodule

// File: rtl/nubus_master_arbiter.sv
// Round-robin sharing of the NuBus card-master port with lock and watchdog.
//   state    | meaning
//   ARB_IDLE | no owner; pick next requester from rr pointer
//   ARB_BUSY | transaction on cpu_*; watchdog running
//   ARB_RESP | one-cycle completion pulse to owner; keep grant if locked
module nubus_master_arbiter
  import nubus_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              nub_clkn,
  input  logic              nub_resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  input  logic [NREQ*4-1:0] req_wstrb,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   req_ready,
  output logic [31:0]       req_rdata,
  output logic              req_err,
  output logic [NREQ-1:0]   grant,
  output logic              cpu_valid,
  output logic [31:0]       cpu_addr,
  output logic [31:0]       cpu_wdata,
  output logic [3:0]        cpu_wstrb,
  output logic              cpu_lock,
  input  logic              cpu_ready,
  input  logic [31:0]       cpu_rdata
);

  localparam int PTR_W = $clog2(NREQ);

  arb_state_t       state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, owner, sel;
  logic [TO_W-1:0]  wdog;
  logic [NREQ-1:0]  pick_onehot;
  logic [PTR_W-1:0] pick_index;
  logic             pick_hit;
  logic             load, relock, finish_ok, finish_err, release_g;

  nubus_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .index  (pick_index),
    .hit    (pick_hit)
  );

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    relock     = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    release_g  = 1'b0;
    case (state)
      ARB_IDLE: if (pick_hit) begin
        load      = 1'b1;
        state_nxt = ARB_BUSY;
      end
      ARB_BUSY: if (cpu_ready) begin
        finish_ok = 1'b1;
        state_nxt = ARB_RESP;
      end else if (wdog == TO_W'(TIMEOUT)) begin
        finish_err = 1'b1;
        state_nxt  = ARB_RESP;
      end
      ARB_RESP: if (cpu_lock && req_valid[owner]) begin
        relock    = 1'b1;
        state_nxt = ARB_BUSY;
      end else begin
        release_g = 1'b1;
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign sel = relock ? owner : pick_index;

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) state <= ARB_IDLE;
    else             state <= state_nxt;
  end

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      rr_ptr    <= '0;
      owner     <= '0;
      wdog      <= '0;
      grant     <= '0;
      req_ready <= '0;
      req_rdata <= '0;
      req_err   <= 1'b0;
      cpu_valid <= 1'b0;
      cpu_addr  <= '0;
      cpu_wdata <= '0;
      cpu_wstrb <= '0;
      cpu_lock  <= 1'b0;
    end else begin
      req_ready <= '0;
      if (state == ARB_BUSY) wdog <= wdog + 1'b1;
      if (state == ARB_RESP) wdog <= '0;
      if (load || relock) begin
        cpu_valid <= 1'b1;
        cpu_addr  <= req_addr[32*sel +: 32];
        cpu_wdata <= req_wdata[32*sel +: 32];
        cpu_wstrb <= req_wstrb[4*sel +: 4];
        cpu_lock  <= req_lock[sel];
      end
      if (load) begin
        grant <= pick_onehot;
        owner <= pick_index;
      end
      // cpu_ready wins over a simultaneous watchdog expiry
      if (finish_ok || finish_err) begin
        cpu_valid <= 1'b0;
        req_ready <= grant;
        req_rdata <= finish_ok ? cpu_rdata : 32'h0;
        req_err   <= finish_err;
      end
      if (release_g) begin
        grant  <= '0;
        rr_ptr <= (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nubus_master_arbiter.sv
// Directed bench for nubus_master_arbiter: requester/responder models driven from one process.
module tb_nubus_master_arbiter;
  import nubus_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int TO   = 16;

  logic              nub_clkn = 1'b0;
  logic              nub_resetn;
  logic [NREQ-1:0]   req_valid, req_lock, req_ready, grant;
  logic [NREQ*32-1:0] req_addr, req_wdata;
  logic [NREQ*4-1:0] req_wstrb;
  logic [31:0]       req_rdata, cpu_addr, cpu_wdata, cpu_rdata;
  logic              req_err, cpu_valid, cpu_lock, cpu_ready;
  logic [3:0]        cpu_wstrb;

  nubus_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TO), .TO_W(8)) dut (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_lock(req_lock), .req_ready(req_ready),
    .req_rdata(req_rdata), .req_err(req_err), .grant(grant),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_lock(cpu_lock), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata)
  );

  always #5 nub_clkn = ~nub_clkn;

  int n_run = 0, n_fail = 0;
  int cyc = 0, bcnt = 0, last_busy = 0, viol = 0, resp_lat = 0;
  int rem [NREQ];
  int nd  [NREQ];
  bit lockm [NREQ];
  logic [31:0] base [NREQ];
  logic [31:0] wdat [NREQ];
  logic [3:0]  strb [NREQ];
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_lock;
  int          done_idx [$];
  int          done_cyc [$];
  logic [31:0] done_data [$];
  logic        done_err [$];
  logic [31:0] rq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_at(input int k);
    return (done_idx.size() > k) ? done_idx[k] : -1;
  endfunction
  function automatic int cyc_at(input int k);
    return (done_cyc.size() > k) ? done_cyc[k] : -1;
  endfunction
  function automatic logic [31:0] data_at(input int k);
    return (done_data.size() > k) ? done_data[k] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic err_at(input int k);
    return (done_err.size() > k) ? done_err[k] : 1'bx;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = rem[i] > 0;
      req_lock[i]           = lockm[i] && (rem[i] > 1);
      req_addr[32*i +: 32]  = base[i] + 32'(nd[i] * 4);
      req_wdata[32*i +: 32] = wdat[i] + 32'(nd[i]);
      req_wstrb[4*i +: 4]   = strb[i];
    end
  endtask

  // One cycle: sample at the falling edge, then update responder and requesters.
  task automatic tick();
    @(negedge nub_clkn);
    cyc++;
    if ($countones(grant) > 1 || $countones(req_ready) > 1) viol++;
    if (cpu_valid) begin
      bcnt++;
      if (bcnt == 1) begin
        cap_addr = cpu_addr; cap_wdata = cpu_wdata;
        cap_wstrb = cpu_wstrb; cap_lock = cpu_lock;
      end
    end else begin
      if (bcnt != 0) last_busy = bcnt;
      bcnt = 0;
    end
    cpu_ready = 1'b0;
    cpu_rdata = 32'h0;
    if (cpu_valid && resp_lat != 0 && bcnt == resp_lat) begin
      cpu_ready = 1'b1;
      if (rq.size() > 0) cpu_rdata = rq.pop_front();
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        done_idx.push_back(i); done_cyc.push_back(cyc);
        done_data.push_back(req_rdata); done_err.push_back(req_err);
        if (rem[i] > 0) begin rem[i]--; nd[i]++; end
      end
    end
    drive();
  endtask

  task automatic run_until_done(input int n, input int budget, input string tag);
    int k = 0;
    while (done_idx.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, done_idx.size(), n);
  endtask

  task automatic do_reset();
    nub_resetn = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; nd[i] = 0; lockm[i] = 1'b0;
      base[i] = 32'h0; wdat[i] = 32'h0; strb[i] = WSTRB_READ;
    end
    done_idx.delete(); done_cyc.delete(); done_data.delete(); done_err.delete(); rq.delete();
    resp_lat = 0;
    cpu_ready = 1'b0; cpu_rdata = 32'h0;
    drive();
    tick(); tick();
    bcnt = 0; last_busy = 0;
    nub_resetn = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_cpu_valid", cpu_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cpu_addr", cpu_addr, 0);
    chk("rst_req_err", req_err, 0);

    // single write from req0
    base[0] = 32'hF000_0000; wdat[0] = 32'h8765_4321; strb[0] = 4'hF;
    rem[0] = 1; resp_lat = 3;
    drive();
    tick();
    chk("t1_latency", cpu_valid, 1);
    run_until_done(1, 50, "t1_done");
    chk("t1_addr", cap_addr, 32'hF000_0000);
    chk("t1_wdata", cap_wdata, 32'h8765_4321);
    chk("t1_wstrb", cap_wstrb, 4'hF);
    chk("t1_owner", idx_at(0), 0);
    chk("t1_busy_cycles", last_busy, 3);
    tick();
    chk("t1_grant_idle", grant, 0);
    chk("t1_ready_once", req_ready, 0);
    chk("t1_count", done_idx.size(), 1);

    // three requesters continuously valid
    do_reset();
    rem[0] = 2; rem[1] = 2; rem[2] = 2; resp_lat = 1;
    drive();
    run_until_done(6, 200, "t2_done");
    for (int k = 0; k < 6; k++) chk($sformatf("t2_order%0d", k), idx_at(k), k % 3);

    // locked pair of reads from req1 with req0 waiting
    do_reset();
    lockm[1] = 1'b1; rem[1] = 2; base[1] = 32'h1000_0000; resp_lat = 2;
    rq.push_back(32'h1111_1111); rq.push_back(32'h2222_2222); rq.push_back(32'h3333_3333);
    drive();
    tick();
    chk("t3_grant1", grant, 3'b010);
    chk("t3_lock", cap_lock, 1);
    rem[0] = 1; base[0] = 32'hA000_0000;
    drive();
    run_until_done(3, 100, "t3_done");
    chk("t3_first", idx_at(0), 1);
    chk("t3_second", idx_at(1), 1);
    chk("t3_third", idx_at(2), 0);
    chk("t3_rdata0", data_at(0), 32'h1111_1111);
    chk("t3_rdata1", data_at(1), 32'h2222_2222);
    chk("t3_rdata2", data_at(2), 32'h3333_3333);
    chk("t3_back_to_back", cyc_at(1) - cyc_at(0), 3);

    // watchdog expiry, then the next requester is served
    do_reset();
    rem[0] = 1; rem[1] = 1; resp_lat = 0;
    drive();
    run_until_done(1, 100, "t4_done");
    chk("t4_owner", idx_at(0), 0);
    chk("t4_err", err_at(0), 1);
    chk("t4_rdata", data_at(0), 0);
    chk("t4_busy_cycles", last_busy, TO + 1);
    chk("t4_cpu_valid", cpu_valid, 0);
    resp_lat = 1;
    run_until_done(2, 100, "t4_next_done");
    chk("t4_next_owner", idx_at(1), 1);
    chk("t4_next_err", err_at(1), 0);

    // cpu_ready on the expiry cycle is a success
    do_reset();
    rem[2] = 1; resp_lat = TO + 1;
    rq.push_back(32'hDEAD_BEEF);
    drive();
    run_until_done(1, 100, "t5_done");
    chk("t5_owner", idx_at(0), 2);
    chk("t5_err", err_at(0), 0);
    chk("t5_rdata", data_at(0), 32'hDEAD_BEEF);
    chk("t5_busy_cycles", last_busy, TO + 1);

    // reset while busy
    do_reset();
    rem[0] = 1; resp_lat = 0;
    drive();
    for (int k = 0; k < 5; k++) tick();
    chk("t6_busy", cpu_valid, 1);
    nub_resetn = 1'b0;
    #1;
    chk("t6_async_valid", cpu_valid, 0);
    chk("t6_async_grant", grant, 0);
    chk("t6_async_ready", req_ready, 0);
    rem[0] = 0; rem[2] = 1; base[2] = 32'h2000_0000;
    drive();
    tick(); tick();
    chk("t6_no_ready", done_idx.size(), 0);
    nub_resetn = 1'b1;
    resp_lat = 1;
    tick();
    chk("t6_grant2", grant, 3'b100);
    chk("t6_addr", cap_addr, 32'h2000_0000);
    run_until_done(1, 50, "t6_done");
    chk("t6_owner", idx_at(0), 2);

    chk("onehot_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
